// File: rtl/block_shifter_scheduler.sv
// block_shifter_scheduler: round-robin pairing of NUM_REQ block producers onto the two shifter input slots.
module block_shifter_scheduler #(
  parameter int BLOCK_SIZE     = 64,
  parameter int MAX_NUM_BLOCKS = 1,
  parameter int NUM_REQ        = 4
) (
  input  logic                                                  clk,
  input  logic                                                  rst_n,
  input  logic                                                  i_start,
  input  logic [NUM_REQ-1:0]                                    i_req_valid,
  output logic [NUM_REQ-1:0]                                    o_req_ready,
  input  logic [NUM_REQ-1:0][MAX_NUM_BLOCKS-1:0][BLOCK_SIZE-1:0] i_req_data,
  input  logic [NUM_REQ-1:0][31:0]                              i_req_num,
  input  logic [NUM_REQ-1:0]                                    i_req_last,
  input  logic                                                  i_ready_4_output,
  output logic [1:0]                                            o_out_valid,
  output logic [1:0][MAX_NUM_BLOCKS-1:0][BLOCK_SIZE-1:0]       o_out_data,
  output logic [1:0][31:0]                                      o_out_num,
  output logic [1:0]                                            o_out_last,
  output logic                                                  o_done,
  output logic [31:0]                                           o_pair_count
);
  localparam int PW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
  state_t r_state, w_state_nxt;
  logic [PW-1:0] r_ptr, w_a, w_b, w_lst, w_sel;
  logic w_a_ok, w_b_ok, w_load, w_clr, w_acc, w_start;
  logic [NUM_REQ-1:0] r_done_mask, w_elig, w_mask_nxt;
  logic [31:0] r_pair_count;
  logic [1:0] r_out_valid, r_out_last, w_sv, w_sl;
  logic [1:0][31:0] r_out_num, w_sn;
  logic [1:0][MAX_NUM_BLOCKS-1:0][BLOCK_SIZE-1:0] r_out_data, w_sd;
  assign w_load = r_state == RUN && (~|r_out_valid || i_ready_4_output);
  assign w_clr = r_state == FLUSH && (~|r_out_valid || i_ready_4_output);
  assign w_acc = |r_out_valid && i_ready_4_output;
  assign w_start = i_start && (r_state == IDLE || r_state == DONE);
  assign w_elig = i_req_valid & ~r_done_mask;
  assign w_mask_nxt = r_done_mask | (o_req_ready & i_req_last);
  assign w_lst = w_b_ok ? w_b : w_a;
  assign w_state_nxt = w_start ? RUN : (r_state == RUN && &w_mask_nxt) ? FLUSH : w_clr ? DONE : r_state;
  always_comb begin
    logic [PW-1:0] j;
    j = '0;
    w_a_ok = 1'b0;
    w_b_ok = 1'b0;
    w_a = '0;
    w_b = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = PW'((int'(r_ptr) + k) % NUM_REQ);
      if (w_elig[j] && !w_a_ok) begin
        w_a_ok = 1'b1;
        w_a = j;
      end else if (w_elig[j] && !w_b_ok) begin
        w_b_ok = 1'b1;
        w_b = j;
      end
    end
  end
  always_comb begin
    o_req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++)
      o_req_ready[i] = w_load && ((w_a_ok && w_a == PW'(i)) || (w_b_ok && w_b == PW'(i)));
  end
  // Unpicked slots carry the empty-slot encoding: valid 0, num 0, last 1, data 0.
  always_comb begin
    w_sv = '0;
    w_sl = '1;
    w_sn = '0;
    w_sd = '0;
    w_sel = w_a;
    for (int s = 0; s < 2; s++) begin
      w_sel = s == 0 ? w_a : w_b;
      w_sv[s] = w_load && (s == 0 ? w_a_ok : w_b_ok);
      if (w_sv[s]) begin
        w_sn[s] = i_req_num[w_sel] > 32'(MAX_NUM_BLOCKS) ? 32'(MAX_NUM_BLOCKS) : i_req_num[w_sel];
        w_sl[s] = i_req_last[w_sel];
        for (int b = 0; b < MAX_NUM_BLOCKS; b++)
          w_sd[s][b] = 32'(b) < w_sn[s] ? i_req_data[w_sel][b] : '0;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_state_nxt;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr <= '0;
      r_done_mask <= '0;
      r_pair_count <= '0;
      r_out_valid <= '0;
      r_out_data <= '0;
      r_out_num <= '0;
      r_out_last <= '1;
    end else begin
      r_done_mask <= w_start ? '0 : w_mask_nxt;
      r_pair_count <= w_start ? '0 : r_pair_count + 32'(w_acc);
      if (w_load && w_a_ok) r_ptr <= w_lst == PW'(NUM_REQ - 1) ? '0 : w_lst + 1'b1;
      if (w_load || w_clr) begin
        r_out_valid <= w_sv;
        r_out_data <= w_sd;
        r_out_num <= w_sn;
        r_out_last <= w_sl;
      end
    end
  end
  assign o_out_valid = r_out_valid;
  assign o_out_data = r_out_data;
  assign o_out_num = r_out_num;
  assign o_out_last = r_out_last;
  assign o_done = r_state == DONE;
  assign o_pair_count = r_pair_count;
endmodule

// File: tb/tb_block_shifter_scheduler.sv
// tb_block_shifter_scheduler: random stimulus against a queue-based reference model with a decoupled pair scoreboard.
module tb_block_shifter_scheduler;
  localparam int BS = 64, MB = 1, NR = 4;
  logic clk = 0, rst_n = 0, start = 0, rdy = 0;
  logic [NR-1:0] rv, rl, o_req_ready;
  logic [NR-1:0][MB-1:0][BS-1:0] rd;
  logic [NR-1:0][31:0] rn;
  logic [1:0] o_out_valid, o_out_last;
  logic [1:0][MB-1:0][BS-1:0] o_out_data;
  logic [1:0][31:0] o_out_num;
  logic o_done;
  logic [31:0] o_pair_count;
  typedef struct {
    logic [1:0] v;
    logic [1:0] l;
    logic [1:0][31:0] n;
    logic [1:0][MB-1:0][BS-1:0] d;
  } pair_t;
  pair_t q[$];
  int errs = 0, checks = 0;
  int m_st = 0, m_ptr = 0;
  logic [NR-1:0] m_mask = '0;
  logic [1:0] m_valid = '0;
  logic [31:0] m_cnt = '0;
  always #5 clk = ~clk;
  block_shifter_scheduler #(.BLOCK_SIZE(BS), .MAX_NUM_BLOCKS(MB), .NUM_REQ(NR)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_req_valid(rv), .o_req_ready(o_req_ready),
    .i_req_data(rd), .i_req_num(rn), .i_req_last(rl), .i_ready_4_output(rdy),
    .o_out_valid(o_out_valid), .o_out_data(o_out_data), .o_out_num(o_out_num),
    .o_out_last(o_out_last), .o_done(o_done), .o_pair_count(o_pair_count)
  );
  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, a, e, $time);
    end
  endtask
  task automatic rand_data();
    for (int i = 0; i < NR; i++) rd[i] = {$urandom, $urandom};
  endtask
  task automatic step();
    int picks[$];
    logic [NR-1:0] er, mn;
    logic ld, acc, fl, so;
    pair_t p;
    #1;
    ld = m_st == 1 && (m_valid == 0 || rdy);
    for (int k = 0; k < NR; k++) begin
      int j = (m_ptr + k) % NR;
      if (rv[j] && !m_mask[j] && picks.size() < 2) picks.push_back(j);
    end
    er = '0;
    if (ld) foreach (picks[i]) er[picks[i]] = 1'b1;
    chk("req_ready", o_req_ready, er);
    if (!rst_n) begin
      m_st = 0; m_ptr = 0; m_mask = '0; m_valid = '0; m_cnt = '0;
      q.delete();
    end else begin
      acc = m_valid != 0 && rdy;
      fl = m_st == 2 && (m_valid == 0 || rdy);
      so = start && (m_st == 0 || m_st == 3);
      mn = m_mask | (er & rl);
      if (acc) m_cnt++;
      if (ld) begin
        for (int s = 0; s < 2; s++) begin
          if (s < picks.size()) begin
            int j = picks[s];
            p.v[s] = 1'b1;
            p.l[s] = rl[j];
            p.n[s] = rn[j] > MB ? MB : rn[j];
            for (int b = 0; b < MB; b++) p.d[s][b] = b < p.n[s] ? rd[j][b] : '0;
          end else begin
            p.v[s] = 1'b0; p.l[s] = 1'b1; p.n[s] = '0; p.d[s] = '0;
          end
        end
        m_valid = p.v;
        if (picks.size() > 0) begin
          q.push_back(p);
          m_ptr = (picks[picks.size()-1] + 1) % NR;
        end
      end else if (fl) m_valid = '0;
      if (so) m_st = 1;
      else if (m_st == 1 && &mn) m_st = 2;
      else if (fl) m_st = 3;
      m_mask = so ? '0 : mn;
      if (so) m_cnt = '0;
    end
    @(posedge clk);
    #1;
    chk("pair_count", o_pair_count, m_cnt);
    chk("done", o_done, m_st == 3);
    chk("out_valid", o_out_valid, m_valid);
    #1;
  endtask
  always @(negedge clk) begin
    pair_t p;
    if (rst_n === 1'b1 && |o_out_valid && rdy) begin
      if (q.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL unexpected_pair actual=%b required=none", o_out_valid);
      end else begin
        p = q.pop_front();
        chk("slot_valid", o_out_valid, p.v);
        chk("slot_last", o_out_last, p.l);
        for (int s = 0; s < 2; s++) begin
          chk("slot_num", o_out_num[s], p.n[s]);
          chk("slot_data", o_out_data[s], p.d[s]);
        end
      end
    end
  end
  initial begin
    rv = '0; rl = '0; rn = '0; rd = '0;
    repeat (2) @(posedge clk);
    #2;
    step();
    rst_n = 1;
    repeat (2) step();
    start = 1; step(); start = 0;
    rv = '1; rdy = 1; rn = {32'd1, 32'd1, 32'd1, 32'd1};
    repeat (4) begin rand_data(); step(); end
    rv = 4'b0100; rn = {32'd1, 32'd1, 32'd1, 32'd1};
    repeat (2) begin rand_data(); step(); end
    rv = '1; rn = {32'd0, 32'd7, 32'd3, 32'd1}; rand_data();
    step(); rdy = 0;
    repeat (5) step();
    rdy = 1;
    repeat (2) begin rand_data(); step(); end
    rdy = 0; step();
    rst_n = 0; step(); rst_n = 1; step();
    start = 1; step(); start = 0;
    repeat (2000) begin
      rv = NR'($urandom);
      rdy = $urandom_range(0, 3) != 0;
      for (int i = 0; i < NR; i++) begin
        rl[i] = $urandom_range(0, 15) == 0;
        rn[i] = $urandom_range(0, 7);
      end
      rand_data();
      start = (m_st == 0 || m_st == 3) ? $urandom_range(0, 3) == 0 : $urandom_range(0, 49) == 0;
      rst_n = $urandom_range(0, 499) != 0;
      step();
    end
    rst_n = 1; start = 0; rv = '0; rl = '0; rdy = 1;
    repeat (3) step();
    start = 1; step(); start = 0;
    rv = '1; rl = '1;
    repeat (5) begin rand_data(); step(); end
    rl = '0;
    repeat (3) step();
    start = 1; step(); start = 0;
    rv = '0;
    repeat (3) step();
    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
